// File: rtl/add_sub_seq_ctrl_if.sv
// Request/response bus for the slice-serial add/subtract sequencer.
// The issuing/consuming side takes the master modport, the sequencer the slave.
interface add_sub_seq_ctrl_if #(
    parameter int N_SLICES = 2
) ();
    localparam int WIDTH = 32 * N_SLICES;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Invert_B;
    logic             C_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             C_out;
    logic             Overflow;
    logic             busy;

    modport master (
        output in_valid, A, B, Invert_B, C_in, out_ready,
        input  in_ready, out_valid, Sum, C_out, Overflow, busy
    );

    modport slave (
        input  in_valid, A, B, Invert_B, C_in, out_ready,
        output in_ready, out_valid, Sum, C_out, Overflow, busy
    );
endinterface

// File: rtl/add_sub_seq_ctrl.sv
// Slice-serial add/subtract sequencer: one shared 32-bit adder slice processes
// the operands least-significant slice first, one slice per clock, carrying
// between slices through a register. All outputs come straight from flops.

// 32-bit adder slice with optional inversion of the B operand.
module full_adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        invert_b,
    input  logic        c_in,
    output logic [31:0] sum,
    output logic        c_out
);
    logic [31:0] b_eff_s;
    logic [32:0] total_s;

    // Add A, the (optionally inverted) B and the carry-in in one 33-bit sum.
    always_comb begin
        b_eff_s = invert_b ? ~b : b;
        total_s = {1'b0, a} + {1'b0, b_eff_s} + {32'd0, c_in};
        sum     = total_s[31:0];
        c_out   = total_s[32];
    end
endmodule

module add_sub_seq_ctrl #(
    parameter int N_SLICES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    add_sub_seq_ctrl_if.slave       bus
);
    localparam int WIDTH = 32 * N_SLICES;
    localparam int IDX_W = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SLICES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [IDX_W-1:0] idx_q,       idx_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] b_q,         b_d;
    logic             inv_q,       inv_d;
    logic             carry_q,     carry_d;
    logic [WIDTH-1:0] sum_q,       sum_d;
    logic             c_out_q,     c_out_d;
    logic             ovf_q,       ovf_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q,      busy_d;

    logic [IDX_W+4:0] shift_s;
    logic [WIDTH-1:0] a_shift_s;
    logic [WIDTH-1:0] b_shift_s;
    logic [31:0]      a_slice_s;
    logic [31:0]      b_slice_s;
    logic [31:0]      slice_sum_s;
    logic             slice_cout_s;
    logic             msb_carry_in_s;

    // Pick the operand slice addressed by the slice counter.
    always_comb begin
        shift_s   = {idx_q, 5'd0};
        a_shift_s = a_q >> shift_s;
        b_shift_s = b_q >> shift_s;
        a_slice_s = a_shift_s[31:0];
        b_slice_s = b_shift_s[31:0];
    end

    full_adder_32bit u_slice (
        .a        (a_slice_s),
        .b        (b_slice_s),
        .invert_b (inv_q),
        .c_in     (carry_q),
        .sum      (slice_sum_s),
        .c_out    (slice_cout_s)
    );

    // Carry into the top bit, recovered from its sum bit; only meaningful on the last slice.
    always_comb begin
        msb_carry_in_s = a_slice_s[31] ^ (b_slice_s[31] ^ inv_q) ^ slice_sum_s[31];
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        inv_d   = inv_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    inv_d   = bus.Invert_B;
                    carry_d = bus.C_in;
                    idx_d   = {IDX_W{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d   = (sum_q & ~(WIDTH'(32'hFFFF_FFFF) << shift_s))
                        | (WIDTH'(slice_sum_s) << shift_s);
                carry_d = slice_cout_s;
                if (idx_q == IDX_LAST) begin
                    c_out_d = slice_cout_s;
                    ovf_d   = msb_carry_in_s ^ slice_cout_s;
                    idx_d   = {IDX_W{1'b0}};
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = RUN;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = {IDX_W{1'b0}};
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= {IDX_W{1'b0}};
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            inv_q       <= 1'b0;
            carry_q     <= 1'b0;
            sum_q       <= {WIDTH{1'b0}};
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            inv_q       <= inv_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            c_out_q     <= c_out_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.Sum       = sum_q;
    assign bus.C_out     = c_out_q;
    assign bus.Overflow  = ovf_q;
    assign bus.busy      = busy_q;
endmodule

// File: doc/add_sub_seq_ctrl.md
Name: add_sub_seq_ctrl

Overview:
Multi-cycle add/subtract sequencer that computes a WIDTH-bit sum by time-multiplexing a single 32-bit adder slice, one slice per clock, least-significant first. It is the area-reduced alternative to chaining full 32-bit adders in parallel. It sits between an issuing unit (valid/ready in) and a consumer (valid/ready out). It instantiates one full_adder_32bit internally and owns operand capture, carry propagation between slices, and result assembly.

Parameters:
N_SLICES, 2, number of 32-bit slices; operand width WIDTH = 32*N_SLICES; legal range 1..8.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept a request
A  input  WIDTH  operand A
B  input  WIDTH  operand B
Invert_B  input  1  1: use ~B (subtract when combined with C_in=1)
C_in  input  1  carry into slice 0
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
Sum  output  WIDTH  result
C_out  output  1  carry out of the top slice
Overflow  output  1  signed overflow of the full-width operation
busy  output  1  high in any state other than IDLE

Behaviour:
- States: IDLE, RUN, DONE. Slice counter idx is $clog2(N_SLICES) bits wide, minimum 1 bit.
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, idx=0.
  - Operand, carry and result registers cleared to 0.
  - Outputs after reset: in_ready=1, out_valid=0, Sum=0, C_out=0, Overflow=0, busy=0.
  - Reset asserted mid-operation aborts the operation. No partial result is ever presented.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture A, B, Invert_B, C_in; set carry register to C_in, idx=0; go to RUN.
  - Inputs are sampled only at acceptance. Later changes to A/B/etc. have no effect.
- RUN:
  - in_ready=0.
  - Each cycle the adder is fed A_cap[idx*32+:32], B_cap[idx*32+:32], Invert_B_cap, and the carry register.
  - The 32-bit slice sum is written into Sum_reg[idx*32+:32]. The slice carry-out is written into the carry register.
  - If idx==N_SLICES-1:
    - C_out := slice carry-out.
    - Overflow := carry-into-MSB XOR carry-out-of-MSB, where carry-into-MSB = A_msb ^ B'_msb ^ Sum_msb and B' = B after optional inversion.
    - Go to DONE. Otherwise idx+1.
- DONE:
  - out_valid=1. Sum/C_out/Overflow are held stable while out_valid=1 and out_ready=0.
  - On out_ready, go to IDLE with out_valid=0 in the next cycle. Sum, C_out and Overflow keep their last values until overwritten.
- Latency: acceptance at edge k gives out_valid=1 after edge k+N_SLICES. Minimum issue interval is N_SLICES+2 cycles. in_ready is low in RUN and DONE; there is no combinational in→out path.
- Arithmetic: modular 2^WIDTH.
  - Invert_B=1 with C_in=1 gives A−B; C_out=1 means no borrow.
  - Invert_B=1 with C_in=0 gives A+~B.
- N_SLICES=1: RUN lasts exactly one cycle.
- out_ready high while not in DONE is ignored. in_valid while in_ready=0 is ignored; requester must hold.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles -> in_ready=1, out_valid=0, Sum=0, C_out=0, Overflow=0, busy=0.
- Carry across slices, N_SLICES=2: A=0x00000000_FFFFFFFF, B=1, Invert_B=0, C_in=0 -> after 2 cycles out_valid=1, Sum=0x00000001_00000000, C_out=0, Overflow=0.
- Full wrap: A=0xFFFFFFFF_FFFFFFFF, B=1 -> Sum=0, C_out=1, Overflow=0. Also A=0x7FFFFFFF_FFFFFFFF, B=1 -> Sum=0x80000000_00000000, Overflow=1, C_out=0.
- Subtract with borrow: A=5, B=7, Invert_B=1, C_in=1 -> Sum=0xFFFFFFFF_FFFFFFFE, C_out=0. A=7, B=5 -> Sum=2, C_out=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, toggling A/B/in_valid -> outputs stable, in_ready=0. out_ready=1 -> IDLE next cycle; next request accepted.
- Reset mid-RUN: assert rst_n=0 on the cycle after acceptance -> next cycle IDLE, out_valid never asserts, Sum=0. A new request afterwards completes correctly.
